// File: rtl/fifo_pkg.sv
// Shared types and helpers for the flagged synchronous FIFO.
// The count typedef is sized for the default ADDR_WIDTH; parametrised users size locally.
package fifo_pkg;

    localparam int unsigned FIFO_DEF_ADDR_WIDTH = 5;

    typedef logic [FIFO_DEF_ADDR_WIDTH:0] fifo_count_t;

    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    // Occupancy from extended pointers: difference taken modulo 2**(addr_width+1).
    function automatic int unsigned ptr_count(input int unsigned wr_ptr,
                                              input int unsigned rd_ptr,
                                              input int unsigned addr_width);
        int unsigned mask;
        mask = (32'd1 << (addr_width + 1)) - 32'd1;
        return (wr_ptr - rd_ptr) & mask;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and flag control for sync_fifo_flags.
// Flags and count decode only from registered pointers and sticky error registers.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned AFULL_LEVEL  = 28,
    parameter int unsigned AEMPTY_LEVEL = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic                  wr_acc,
    output logic                  rd_acc,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;

    assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = CW'(ptr_count(32'(wr_ptr), 32'(rd_ptr), ADDR_WIDTH));

    assign almost_full  = (32'(count) >= AFULL_LEVEL);
    assign almost_empty = (32'(count) <= AEMPTY_LEVEL);

    assign wr_acc  = wr_en && !full && !flush;
    assign rd_acc  = rd_en && !empty && !flush;
    assign wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            if (wr_en && full)  overflow  <= 1'b1;
            if (rd_en && empty) underflow <= 1'b1;
        end
    end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with count, almost flags, sticky errors and flush.
// Define FIFO_FWFT_EN for first-word fall-through data_out; default is 1-cycle registered read.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter  int unsigned ADDR_WIDTH   = 5,
    parameter  int unsigned DATA_WIDTH   = 32,
    localparam int unsigned DEPTH        = fifo_depth(ADDR_WIDTH),
    parameter  int unsigned AFULL_LEVEL  = DEPTH - 4,
    parameter  int unsigned AEMPTY_LEVEL = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  Wr_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  Read_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    if (!(AEMPTY_LEVEL > 0 && AEMPTY_LEVEL < AFULL_LEVEL && AFULL_LEVEL < DEPTH)) begin : g_bad_levels
        $error("sync_fifo_flags: need 0 < AEMPTY_LEVEL < AFULL_LEVEL < DEPTH");
    end

    logic                  wr_acc;
    logic                  rd_acc;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    fifo_ptr_ctrl #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .AFULL_LEVEL  (AFULL_LEVEL),
        .AEMPTY_LEVEL (AEMPTY_LEVEL)
    ) u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .wr_en        (Wr_enable),
        .rd_en        (Read_enable),
        .wr_acc       (wr_acc),
        .rd_acc       (rd_acc),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_addr] <= data_in;
    end

`ifdef FIFO_FWFT_EN
    assign data_out = empty ? '0 : mem[rd_addr];
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
        end else if (flush) begin
            data_out <= '0;
        end else if (rd_acc) begin
            data_out <= mem[rd_addr];
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags (DEPTH=4) using a queue-based reference model.
module tb_sync_fifo_flags;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       Wr_enable;
    logic [7:0] data_in;
    logic       Read_enable;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int tests = 0;
    int fails = 0;

    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic [7:0] m_dout = 8'h00;

    sync_fifo_flags #(
        .ADDR_WIDTH   (2),
        .DATA_WIDTH   (8),
        .AFULL_LEVEL  (3),
        .AEMPTY_LEVEL (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .Wr_enable    (Wr_enable),
        .data_in      (data_in),
        .Read_enable  (Read_enable),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_dout();
`ifdef FIFO_FWFT_EN
        return (q.size() == 0) ? 8'h00 : q[0];
`else
        return m_dout;
`endif
    endfunction

    task automatic model_clear();
        q.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_dout = 8'h00;
    endtask

    task automatic model_step(input bit w, input logic [7:0] d, input bit r, input bit f);
        bit was_full;
        bit was_empty;
        if (f) begin
            model_clear();
        end else begin
            was_full  = (q.size() == 4);
            was_empty = (q.size() == 0);
            if (w && was_full)  m_ovf = 1'b1;
            if (r && was_empty) m_udf = 1'b1;
            if (r && !was_empty) m_dout = q.pop_front();
            if (w && !was_full)  q.push_back(d);
        end
    endtask

    task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit f);
        Wr_enable   = w;
        data_in     = d;
        Read_enable = r;
        flush       = f;
        @(posedge clk);
        if (!reset) model_step(w, d, r, f);
        #1;
        Wr_enable   = 1'b0;
        Read_enable = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        check("cmp_count",  32'(count),        32'(q.size()));
        check("cmp_full",   32'(full),         (q.size() == 4) ? 32'd1 : 32'd0);
        check("cmp_empty",  32'(empty),        (q.size() == 0) ? 32'd1 : 32'd0);
        check("cmp_afull",  32'(almost_full),  (q.size() >= 3) ? 32'd1 : 32'd0);
        check("cmp_aempty", 32'(almost_empty), (q.size() <= 1) ? 32'd1 : 32'd0);
        check("cmp_ovf",    32'(overflow),     32'(m_ovf));
        check("cmp_udf",    32'(underflow),    32'(m_udf));
        check("cmp_dout",   32'(data_out),     32'(exp_dout()));
    end

    initial begin
        reset = 1'b1; flush = 1'b0; Wr_enable = 1'b0; Read_enable = 1'b0; data_in = 8'h00;
        #2;
        check("rst_count",  32'(count),        32'd0);
        check("rst_empty",  32'(empty),        32'd1);
        check("rst_full",   32'(full),         32'd0);
        check("rst_aempty", 32'(almost_empty), 32'd1);
        check("rst_afull",  32'(almost_full),  32'd0);
        check("rst_ovf",    32'(overflow),     32'd0);
        check("rst_udf",    32'(underflow),    32'd0);
        check("rst_dout",   32'(data_out),     32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fill then drain
        cycle(1, 8'h11, 0, 0); check("fill1_count", 32'(count), 32'd1); check("fill1_af", 32'(almost_full), 32'd0);
        cycle(1, 8'h22, 0, 0); check("fill2_count", 32'(count), 32'd2);
        cycle(1, 8'h33, 0, 0); check("fill3_count", 32'(count), 32'd3); check("fill3_af", 32'(almost_full), 32'd1);
        check("fill3_full", 32'(full), 32'd0);
        cycle(1, 8'h44, 0, 0); check("fill4_count", 32'(count), 32'd4); check("fill4_full", 32'(full), 32'd1);
        check("fill4_ovf", 32'(overflow), 32'd0);
        cycle(1, 8'h55, 0, 0); check("ovf_set", 32'(overflow), 32'd1); check("ovf_count", 32'(count), 32'd4);
        cycle(0, 8'h00, 1, 0);
`ifndef FIFO_FWFT_EN
        check("rd1_dout", 32'(data_out), 32'h11);
`endif
        check("rd1_ovf_sticky", 32'(overflow), 32'd1);
        cycle(0, 8'h00, 1, 0);
`ifndef FIFO_FWFT_EN
        check("rd2_dout", 32'(data_out), 32'h22);
`endif
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 0);
`ifndef FIFO_FWFT_EN
        check("rd4_dout", 32'(data_out), 32'h44);
`endif
        check("drain_empty", 32'(empty), 32'd1);

        // Underflow right after reset
        pulse_reset();
        cycle(0, 8'h00, 1, 0);
        check("udf_set",   32'(underflow), 32'd1);
        check("udf_dout",  32'(data_out),  32'd0);
        check("udf_count", 32'(count),     32'd0);

        // Simultaneous access at count 2, pointers wrap
        cycle(1, 8'h01, 0, 0);
        cycle(1, 8'h02, 0, 0);
        for (int k = 0; k < 6; k++) begin
            cycle(1, 8'(3 + k), 1, 0);
            check("sim_count", 32'(count), 32'd2);
`ifndef FIFO_FWFT_EN
            check("sim_dout", 32'(data_out), 32'(1 + k));
`endif
        end
        check("sim_ovf", 32'(overflow), 32'd0);
        cycle(1, 8'h09, 0, 0);
        cycle(1, 8'h0A, 0, 0);
        check("sim_full", 32'(full), 32'd1);
        cycle(1, 8'hEE, 1, 0);
        check("simfull_count", 32'(count), 32'd3);
        check("simfull_ovf",   32'(overflow), 32'd1);
`ifndef FIFO_FWFT_EN
        check("simfull_dout", 32'(data_out), 32'h07);
`endif

        // Flush with both error flags set and a concurrent write
        check("preflush_udf", 32'(underflow), 32'd1);
        cycle(1, 8'hBB, 0, 1);
        check("flush_count", 32'(count),     32'd0);
        check("flush_empty", 32'(empty),     32'd1);
        check("flush_ovf",   32'(overflow),  32'd0);
        check("flush_udf",   32'(underflow), 32'd0);
        check("flush_dout",  32'(data_out),  32'd0);
        cycle(0, 8'h00, 0, 0);
        check("flush_wr_ignored", 32'(count), 32'd0);

        // Asynchronous reset between edges during a write burst
        cycle(1, 8'h61, 0, 0);
        cycle(1, 8'h62, 0, 0);
        Wr_enable = 1'b1;
        data_in   = 8'h63;
        #3;
        reset = 1'b1;
        model_clear();
        #1;
        check("arst_count", 32'(count),        32'd0);
        check("arst_empty", 32'(empty),        32'd1);
        check("arst_full",  32'(full),         32'd0);
        check("arst_ae",    32'(almost_empty), 32'd1);
        check("arst_dout",  32'(data_out),     32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        Wr_enable = 1'b0;
        cycle(0, 8'h00, 1, 0);
        check("arst_rd_empty", 32'(empty),     32'd1);
        check("arst_rd_udf",   32'(underflow), 32'd1);

        // Single write, no read
        cycle(1, 8'hA5, 0, 0);
        check("wr_a5_empty", 32'(empty), 32'd0);
`ifdef FIFO_FWFT_EN
        check("fwft_dout", 32'(data_out), 32'hA5);
`else
        check("std_hold_dout", 32'(data_out), 32'h00);
`endif
        cycle(0, 8'h00, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Parametrised single-clock FIFO; next generation of the team's basic synchronous FIFO.
- Uses all 2**ADDR_WIDTH entries, not DEPTH-1, by using extended pointers.
- Adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush.
- Sits between producer and consumer datapaths in the same clock domain.

Parameters:
- ADDR_WIDTH, 5, log2 of depth.
- DATA_WIDTH, 32, width of each entry.
- DEPTH, 2**ADDR_WIDTH, number of entries; derived, never overridden.
- AFULL_LEVEL, DEPTH-4, almost_full asserts when count >= AFULL_LEVEL.
- AEMPTY_LEVEL, 4, almost_empty asserts when count <= AEMPTY_LEVEL.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of pointers, count and error flags.
- Wr_enable  input  1  write request.
- data_in  input  DATA_WIDTH  write data.
- Read_enable  input  1  read request.
- data_out  output  DATA_WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_LEVEL.
- almost_empty  output  1  count <= AEMPTY_LEVEL.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset values: data_out=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
- Pointers: write and read pointers are ADDR_WIDTH+1 bits and reset to 0. Storage array is not reset; contents are undefined until written.
- full/empty decoding: full when pointer MSBs differ and the low bits are equal. empty when the pointers are equal.
- All flags and count are registered (or decoded from registered pointers). No combinational path from any input to any flag.
- Accepted write: Wr_enable && !full. Stores data_in at wr_ptr[ADDR_WIDTH-1:0], then wr_ptr+1.
- Accepted read: Read_enable && !empty. Increments rd_ptr.
  - Standard mode: data_out <= mem[rd_ptr] on the same edge, so data is visible the cycle after the request (1-cycle latency).
  - data_out holds its value when no read is accepted.
- Write and read in the same cycle: each is qualified independently against the pre-edge full/empty.
  - Full: the read is accepted, the write is rejected, overflow is set; count becomes DEPTH-1.
  - Empty: the write is accepted, the read is rejected, underflow is set; count becomes 1.
  - Otherwise: both are accepted and count is unchanged.
- count arithmetic: count_next = count + wr_acc - rd_acc. Pointer wrap is modulo 2**(ADDR_WIDTH+1).
- overflow: set on Wr_enable && full. underflow: set on Read_enable && empty. Both are cleared only by reset or flush.
- flush: takes priority over simultaneous read and write. Pointers, count, overflow and underflow go to 0 and data_out goes to 0. Flags show the empty state on the next cycle.
- Reset mid-operation: all state returns to reset values immediately, asynchronously. Operation resumes on the first clk edge after reset deasserts.
- Flag threshold parameters are legal when 0 < AEMPTY_LEVEL < AFULL_LEVEL < DEPTH. Illegal values are an elaboration error, checked by a generate-time guard.

Optional Feature:
- Macro: FIFO_FWFT_EN (first-word fall-through).
- Defined:
  - data_out continuously presents mem[rd_ptr] while !empty, and 0 when empty.
  - The first word written appears on data_out the cycle after the write, with empty deasserted.
  - An accepted read pops the entry; the next word is presented the following cycle.
  - Read latency is 0 relative to empty deasserting.
- Undefined: registered 1-cycle read latency as described in Behaviour.
- All flags, count and error behaviour are identical in both builds.

Decomposition:
- Package fifo_pkg:
  - function for pointer-to-count difference;
  - localparam helper for DEPTH from ADDR_WIDTH;
  - typedef of the count width (ADDR_WIDTH+1).
- Sub-module fifo_ptr_ctrl: pointers, accept qualification, count, full/empty/almost flags and sticky errors.
- The top level holds the storage array and the data_out path, including the FWFT mux.

Test Plan (ADDR_WIDTH=2, DEPTH=4, AFULL_LEVEL=3, AEMPTY_LEVEL=1, DATA_WIDTH=8):
- Fill then drain:
  - Write 0x11,0x22,0x33,0x44 -> count 1,2,3,4; almost_full at count 3; full at 4; overflow=0.
  - Then 4 reads -> data_out 0x11..0x44 in order; empty=1 after the last read.
- Overflow: write 0x55 while full -> overflow=1 and stays 1. A later read still returns 0x11. Count never exceeds 4.
- Underflow: Read_enable while empty after reset -> underflow=1, data_out stays 0x00, count=0.
- Simultaneous access: with count=2, hold Wr_enable and Read_enable for 6 cycles -> count stays 2, data stays in order, pointers wrap past 3 without error. At full, simultaneous access -> count 3, overflow=1.
- Flush: with count=3 and both error flags set, pulse flush together with Wr_enable -> next cycle count=0, empty=1, overflow=underflow=0, write ignored.
- Async reset mid-burst: assert reset between clock edges during writes -> outputs hit reset values before the next edge. Reads after release show empty.
- FIFO_FWFT_EN build: write 0xA5 -> data_out=0xA5 one cycle later with empty=0 and no read issued.
